dpe_demultiplexer: RTL and testbench



---
 rtl/dpe_demultiplexer_pkg.sv | 20 ++
 rtl/dpe_demultiplexer_stage.sv | 54 +++++
 rtl/dpe_demultiplexer.sv | 130 +++++++++++++
 tb/tb_dpe_demultiplexer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpe_demultiplexer_pkg.sv
// Shared definitions for the DPE packet demultiplexer: destination count,
// FSM state encoding and the one-hot destination test.
package dpe_demultiplexer_pkg;

    // Number of destination streams; one tuser bit selects each of them.
    localparam int unsigned NUM_DEST = 5;

    // Packet-level FSM states.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HEAD = 2'd1;
    localparam state_t ST_PASS = 2'd2;
    localparam state_t ST_DROP = 2'd3;

    // A destination is routable only when exactly one select bit is set.
    function automatic logic is_onehot(input logic [NUM_DEST-1:0] v);
        return (v != '0) && ((v & (v - NUM_DEST'(1))) == '0);
    endfunction

endpackage

// File: rtl/dpe_demultiplexer_stage.sv
// Single-beat registered output stage for one demultiplexer destination.
// Loads and unloads in the same cycle, so a ready sink sees one beat/cycle.
module dpe_demux_stage
    import dpe_demultiplexer_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 128,
    parameter int unsigned TUSER_WIDTH = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  logic [TDATA_WIDTH-1:0]   i_tdata,
    input  logic [TDATA_WIDTH/8-1:0] i_tkeep,
    input  logic                     i_tlast,
    input  logic [TUSER_WIDTH-1:0]   i_tuser,
    output logic                     o_ready,
    output logic                     o_tvalid,
    input  logic                     i_tready,
    output logic [TDATA_WIDTH-1:0]   o_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_tkeep,
    output logic                     o_tlast,
    output logic [TUSER_WIDTH-1:0]   o_tuser
);

    logic r_vld;

    // Valid flag: set on load, cleared when the sink takes the beat.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld <= 1'b1;
        end else if (i_tready) begin
            r_vld <= 1'b0;
        end
    end

    // Payload register; contents are only meaningful while r_vld is set.
    always_ff @(posedge i_clk) begin
        if (i_load) begin
            o_tdata <= i_tdata;
            o_tkeep <= i_tkeep;
            o_tlast <= i_tlast;
            o_tuser <= i_tuser;
        end
    end

    // Stage can accept a new beat when empty or draining this cycle.
    always_comb begin
        o_ready  = !r_vld || i_tready;
        o_tvalid = r_vld;
    end

endmodule

// File: rtl/dpe_demultiplexer.sv
// Packet demultiplexer: routes each packet to the output selected by the
// one-hot tuser of its first beat, drops packets with an invalid select,
// and parks in IDLE at a packet boundary when pause is requested.
module dpe_demultiplexer
    import dpe_demultiplexer_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 128,
    parameter int unsigned TUSER_WIDTH = 5
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      pause,
    output logic                                      is_idle,
    input  logic                                      inp_tvalid,
    output logic                                      inp_tready,
    input  logic [TDATA_WIDTH-1:0]                    inp_tdata,
    input  logic [TDATA_WIDTH/8-1:0]                  inp_tkeep,
    input  logic                                      inp_tlast,
    input  logic [TUSER_WIDTH-1:0]                    inp_tuser,
    output logic [NUM_DEST-1:0]                       outp_tvalid,
    input  logic [NUM_DEST-1:0]                       outp_tready,
    output logic [NUM_DEST-1:0][TDATA_WIDTH-1:0]      outp_tdata,
    output logic [NUM_DEST-1:0][TDATA_WIDTH/8-1:0]    outp_tkeep,
    output logic [NUM_DEST-1:0]                       outp_tlast,
    output logic [NUM_DEST-1:0][TUSER_WIDTH-1:0]      outp_tuser,
    output logic [15:0]                               drop_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_DEST-1:0] r_dest;
    logic [NUM_DEST-1:0] w_hdr_dest;
    logic [NUM_DEST-1:0] w_cur_dest;
    logic [NUM_DEST-1:0] w_stage_ready;
    logic [NUM_DEST-1:0] w_load;
    logic                w_hdr_ok;
    logic                w_sel_ready;
    logic                w_hs;
    logic                w_drop_pkt;
    logic [15:0]         r_drop_cnt;

    // Routing decode, input handshake and per-output load strobes.
    always_comb begin
        w_hdr_dest  = inp_tuser[NUM_DEST-1:0];
        w_hdr_ok    = is_onehot(w_hdr_dest);
        // First beat routes on its own tuser; later beats use the latched select.
        w_cur_dest  = (r_state == ST_HEAD) ? w_hdr_dest : r_dest;
        w_sel_ready = |(w_cur_dest & w_stage_ready);
        case (r_state)
            ST_HEAD: inp_tready = w_hdr_ok ? w_sel_ready : 1'b1;
            ST_PASS: inp_tready = w_sel_ready;
            ST_DROP: inp_tready = 1'b1;
            default: inp_tready = 1'b0;
        endcase
        w_hs       = inp_tvalid && inp_tready;
        w_drop_pkt = w_hs && (r_state == ST_HEAD) && !w_hdr_ok;
        w_load     = '0;
        if (w_hs && (((r_state == ST_HEAD) && w_hdr_ok) || (r_state == ST_PASS))) begin
            w_load = w_cur_dest;
        end
    end

    // Next-state logic; pause is honoured only in HEAD or at a tlast handshake.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!pause) w_next_state = ST_HEAD;
            end
            ST_HEAD: begin
                if (!inp_tvalid) begin
                    if (pause) w_next_state = ST_IDLE;
                end else if (w_hs) begin
                    if (inp_tlast)     w_next_state = pause ? ST_IDLE : ST_HEAD;
                    else if (w_hdr_ok) w_next_state = ST_PASS;
                    else               w_next_state = ST_DROP;
                end
            end
            default: begin
                if (w_hs && inp_tlast) w_next_state = pause ? ST_IDLE : ST_HEAD;
            end
        endcase
    end

    // FSM state, latched destination and saturating drop counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dest     <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_hs && (r_state == ST_HEAD) && w_hdr_ok) begin
                r_dest <= w_hdr_dest;
            end
            if (w_drop_pkt && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    // Status outputs.
    always_comb begin
        drop_cnt = r_drop_cnt;
        is_idle  = (r_state == ST_IDLE) && (outp_tvalid == '0);
    end

    for (genvar k = 0; k < NUM_DEST; k++) begin : g_stage
        dpe_demux_stage #(
            .TDATA_WIDTH(TDATA_WIDTH),
            .TUSER_WIDTH(TUSER_WIDTH)
        ) u_stage (
            .i_clk    (clk),
            .i_rst    (rst),
            .i_load   (w_load[k]),
            .i_tdata  (inp_tdata),
            .i_tkeep  (inp_tkeep),
            .i_tlast  (inp_tlast),
            .i_tuser  (TUSER_WIDTH'(w_cur_dest)),
            .o_ready  (w_stage_ready[k]),
            .o_tvalid (outp_tvalid[k]),
            .i_tready (outp_tready[k]),
            .o_tdata  (outp_tdata[k]),
            .o_tkeep  (outp_tkeep[k]),
            .o_tlast  (outp_tlast[k]),
            .o_tuser  (outp_tuser[k])
        );
    end

endmodule

// File: tb/tb_dpe_demultiplexer.sv
// Self-checking bench for dpe_demultiplexer: packet-level reference model
// (route whole packet by first-beat select, or count it as dropped) with
// per-output expected/observed queues.
module tb_dpe_demultiplexer;

    typedef struct packed {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [4:0]   user;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  pause = 1'b0;
    logic                  is_idle;
    logic                  inp_tvalid = 1'b0;
    logic                  inp_tready;
    logic [127:0]          inp_tdata = '0;
    logic [15:0]           inp_tkeep = '0;
    logic                  inp_tlast = 1'b0;
    logic [4:0]            inp_tuser = '0;
    logic [4:0]            outp_tvalid;
    logic [4:0]            outp_tready = '1;
    logic [4:0][127:0]     outp_tdata;
    logic [4:0][15:0]      outp_tkeep;
    logic [4:0]            outp_tlast;
    logic [4:0][4:0]       outp_tuser;
    logic [15:0]           drop_cnt;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    exp_drops = 0;
    bit    bp_random = 1'b0;
    logic [4:0] fixed_ready = '1;

    beat_t exp_q   [5][$];
    beat_t obs_q   [5][$];
    int    obs_cyc [5][$];
    int    in_cyc  [$];

    dpe_demultiplexer #(
        .TDATA_WIDTH(128),
        .TUSER_WIDTH(5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pause       (pause),
        .is_idle     (is_idle),
        .inp_tvalid  (inp_tvalid),
        .inp_tready  (inp_tready),
        .inp_tdata   (inp_tdata),
        .inp_tkeep   (inp_tkeep),
        .inp_tlast   (inp_tlast),
        .inp_tuser   (inp_tuser),
        .outp_tvalid (outp_tvalid),
        .outp_tready (outp_tready),
        .outp_tdata  (outp_tdata),
        .outp_tkeep  (outp_tkeep),
        .outp_tlast  (outp_tlast),
        .outp_tuser  (outp_tuser),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink readiness: fixed pattern or 75% random per output.
    always @(posedge clk) begin
        #2;
        if (bp_random) begin
            for (int k = 0; k < 5; k++) outp_tready[k] = ($urandom_range(0, 3) != 0);
        end else begin
            outp_tready = fixed_ready;
        end
    end

    // Record every beat taken by a sink.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            for (int k = 0; k < 5; k++) begin
                if (outp_tvalid[k] && outp_tready[k]) begin
                    b.data = outp_tdata[k];
                    b.keep = outp_tkeep[k];
                    b.last = outp_tlast[k];
                    b.user = outp_tuser[k];
                    obs_q[k].push_back(b);
                    obs_cyc[k].push_back(cyc);
                end
            end
        end
    end

    task automatic clear_sb();
        for (int k = 0; k < 5; k++) begin
            exp_q[k].delete();
            obs_q[k].delete();
            obs_cyc[k].delete();
        end
        in_cyc.delete();
    endtask

    task automatic drive_beat(input beat_t b, output int stamp);
        int n = 0;
        inp_tvalid = 1'b1;
        inp_tdata  = b.data;
        inp_tkeep  = b.keep;
        inp_tlast  = b.last;
        inp_tuser  = b.user;
        stamp = -1;
        while (stamp < 0) begin
            @(negedge clk);
            if (inp_tready) begin
                stamp = cyc;
            end else if (++n > 500) begin
                checks++;
                errors++;
                $display("FAIL beat_accept: inp_tready stayed %b for %0d cycles, required 1", inp_tready, n);
                stamp = 0;
            end
        end
        @(posedge clk);
        #1;
        inp_tvalid = 1'b0;
    endtask

    // Model: a one-hot first-beat select sends the whole packet (tuser rewritten
    // to that select) to its output; anything else is one dropped packet.
    task automatic send_packet(input int len, input logic [4:0] user0, input int gap_max);
        beat_t b;
        beat_t e;
        int    st;
        int    dst = 0;
        bit    ok = ($countones(user0) == 1);
        for (int k = 0; k < 5; k++) if (user0[k]) dst = k;
        for (int i = 0; i < len; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = 16'($urandom);
            b.last = (i == len - 1);
            b.user = (i == 0) ? user0 : 5'($urandom);
            if (ok) begin
                e = b;
                e.user = user0;
                exp_q[dst].push_back(e);
            end
            drive_beat(b, st);
            in_cyc.push_back(st);
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (!ok) exp_drops++;
    endtask

    task automatic wait_drain();
        int  n = 0;
        bit  done = 1'b0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            done = 1'b1;
            for (int k = 0; k < 5; k++) if (obs_q[k].size() < exp_q[k].size()) done = 1'b0;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: outputs not drained after %0d cycles, required drained", n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL reset_is_idle: got %b expected 1", is_idle); end
        checks++; if (outp_tvalid !== 5'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 00000", outp_tvalid); end
        checks++; if (inp_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", inp_tready); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL post_reset_idle: got %b expected 1", is_idle); end
    endtask

    task automatic test_route();
        @(posedge clk);
        #1;
        clear_sb();
        send_packet(3, 5'b00100, 0);
        wait_drain();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                errors++;
                $display("FAIL route_count[%0d]: got %0d beats expected %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        errors++;
                        $display("FAIL route_beat[%0d][%0d]: got %h expected %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        if (obs_cyc[2].size() == 3 && in_cyc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (obs_cyc[2][i] != in_cyc[i] + 1) begin
                    errors++;
                    $display("FAIL route_latency[%0d]: got cycle %0d expected %0d", i, obs_cyc[2][i], in_cyc[i] + 1);
                end
            end
            checks++;
            if (obs_q[2][2].last !== 1'b1 || obs_q[2][0].user !== 5'b00100) begin
                errors++;
                $display("FAIL route_fields: got last=%b user=%b expected last=1 user=00100", obs_q[2][2].last, obs_q[2][0].user);
            end
        end
    endtask

    task automatic test_drop();
        @(posedge clk);
        #1;
        clear_sb();
        send_packet(3, 5'b00000, 0);
        send_packet(2, 5'b00011, 0);
        repeat (5) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != 0) begin
                errors++;
                $display("FAIL drop_silent[%0d]: got %0d beats expected 0", k, obs_q[k].size());
            end
        end
        checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL drop_cnt: got %0d expected 2", drop_cnt); end
        checks++; if (drop_cnt !== 16'(exp_drops)) begin errors++; $display("FAIL drop_model: got %0d expected %0d", drop_cnt, exp_drops); end
    endtask

    task automatic test_backpressure();
        @(posedge clk);
        #1;
        clear_sb();
        fixed_ready = 5'b11101;
        fork
            send_packet(4, 5'b00010, 0);
            begin
                repeat (6) @(negedge clk);
                checks++; if (inp_tready !== 1'b0) begin errors++; $display("FAIL bp_tready: got %b expected 0", inp_tready); end
                checks++; if (outp_tvalid !== 5'b00010) begin errors++; $display("FAIL bp_hold_valid: got %b expected 00010", outp_tvalid); end
                checks++;
                if (outp_tdata[1] !== exp_q[1][0].data) begin
                    errors++;
                    $display("FAIL bp_hold_data: got %h expected %h", outp_tdata[1], exp_q[1][0].data);
                end
                @(posedge clk);
                #1;
                fixed_ready = '1;
            end
        join
        wait_drain();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                errors++;
                $display("FAIL bp_count[%0d]: got %0d beats expected %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        errors++;
                        $display("FAIL bp_beat[%0d][%0d]: got %h expected %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
    endtask

    task automatic test_pause();
        int n;
        @(posedge clk);
        #1;
        clear_sb();
        fork
            send_packet(4, 5'b00001, 0);
            begin
                n = 0;
                while (in_cyc.size() < 1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk);
                #1;
                pause = 1'b1;
            end
        join
        n = 0;
        while (is_idle !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL pause_idle: got %b expected 1", is_idle); end
        @(posedge clk);
        #1;
        inp_tvalid = 1'b1;
        inp_tuser  = 5'b00001;
        inp_tlast  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++; if (inp_tready !== 1'b0) begin errors++; $display("FAIL pause_tready: got %b expected 0", inp_tready); end
        end
        @(posedge clk);
        #1;
        inp_tvalid = 1'b0;
        pause = 1'b0;
        send_packet(2, 5'b01000, 0);
        wait_drain();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                errors++;
                $display("FAIL pause_count[%0d]: got %0d beats expected %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        errors++;
                        $display("FAIL pause_beat[%0d][%0d]: got %h expected %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        beat_t b;
        int    st;
        @(posedge clk);
        #1;
        fixed_ready = '1;
        for (int i = 0; i < 2; i++) begin
            b.data = {$urandom, $urandom, $urandom, $urandom};
            b.keep = 16'hFFFF;
            b.last = 1'b0;
            b.user = 5'b01000;
            drive_beat(b, st);
        end
        inp_tvalid = 1'b1;
        inp_tlast  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (outp_tvalid !== 5'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b expected 00000", outp_tvalid); end
        checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop_cnt: got %0d expected 0", drop_cnt); end
        checks++; if (is_idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle: got %b expected 1", is_idle); end
        checks++; if (inp_tready !== 1'b0) begin errors++; $display("FAIL rstmid_tready: got %b expected 0", inp_tready); end
        @(posedge clk);
        #1;
        inp_tvalid = 1'b0;
        rst = 1'b0;
        clear_sb();
        exp_drops = 0;
        send_packet(3, 5'b01000, 0);
        wait_drain();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                errors++;
                $display("FAIL rstmid_count[%0d]: got %0d beats expected %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        errors++;
                        $display("FAIL rstmid_beat[%0d][%0d]: got %h expected %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] u;
        @(posedge clk);
        #1;
        clear_sb();
        bp_random = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            if ($urandom_range(0, 9) < 7) u = 5'(1 << $urandom_range(0, 4));
            else                          u = 5'($urandom);
            send_packet($urandom_range(1, 6), u, 2);
        end
        wait_drain();
        bp_random = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (obs_q[k].size() != exp_q[k].size()) begin
                errors++;
                $display("FAIL random_count[%0d]: got %0d beats expected %0d", k, obs_q[k].size(), exp_q[k].size());
            end else begin
                for (int i = 0; i < exp_q[k].size(); i++) begin
                    checks++;
                    if (obs_q[k][i] !== exp_q[k][i]) begin
                        errors++;
                        $display("FAIL random_beat[%0d][%0d]: got %h expected %h", k, i, obs_q[k][i], exp_q[k][i]);
                    end
                end
            end
        end
        checks++;
        if (drop_cnt !== 16'(exp_drops)) begin
            errors++;
            $display("FAIL random_drop_cnt: got %0d expected %0d", drop_cnt, exp_drops);
        end
    endtask

    initial begin
        test_reset();
        test_route();
        test_drop();
        test_backpressure();
        test_pause();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
